// File: rtl/shseq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shseq_pkg
// Description : Shared definitions for the multi-cycle shift sequencer:
//               shift function codes, FSM state encoding and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package shseq_pkg;

    // Default datapath geometry for this core
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;
    localparam int DEF_STEP    = 4;

    // Shift function codes carried on in_funct
    localparam logic [1:0] FN_SLL  = 2'b00;
    localparam logic [1:0] FN_SRL  = 2'b01;
    localparam logic [1:0] FN_SRL2 = 2'b10;
    localparam logic [1:0] FN_SRA  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : shseq_pkg
`default_nettype wire

// File: rtl/shifter.sv
`default_nettype none
// ============================================================================
// Module      : shifter
// Description : Combinational barrel shifter. SLL zero-fills from the right,
//               SRL (both encodings) zero-fills from the left, SRA replicates
//               the sign bit.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter
    import shseq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic [1:0]         funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] n,
    output logic [WIDTH-1:0]   r
);

    // Select the shift flavour; anything that is not SLL or SRA is logical right
    always_comb begin
        r = a >> n;
        case (funct)
            FN_SLL:  r = a << n;
            FN_SRA:  r = WIDTH'($signed(a) >>> n);
            default: r = a >> n;
        endcase
    end

endmodule : shifter
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle shift controller. Accepts one shift op over a
//               valid/ready handshake, applies it in chunks of at most STEP
//               bits per cycle through a narrow shifter, and returns the
//               result over a second valid/ready handshake.
//               Optional macro SHSEQ_FLUSH_EN adds a synchronous flush input
//               that aborts any op in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shseq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int STEP    = DEF_STEP
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SHSEQ_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_funct,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [SHAMT_W-1:0] in_n,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_r,
    output logic               busy
);

    localparam logic [SHAMT_W-1:0] STEP_N = SHAMT_W'(STEP);

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     shifted;
    logic [SHAMT_W-1:0]   rem;
    logic [SHAMT_W-1:0]   step;
    logic [SHAMT_W-1:0]   rem_after;
    logic [1:0]           funct_q;
    logic                 accept;
    logic                 flush_now;

`ifdef SHSEQ_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // A request is only taken in IDLE and never in the same cycle as a flush
    assign accept    = in_valid && (state == S_IDLE) && !flush_now;

    // Chunk size for this cycle and the count left over after it
    assign step      = (rem < STEP_N) ? rem : STEP_N;
    assign rem_after = rem - step;

    shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .funct (funct_q),
        .a     (acc),
        .n     (step),
        .r     (shifted)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; flush overrides every transition
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_r      = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = (in_n == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (rem_after == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_r     = acc;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (flush_now) begin
            state_next = S_IDLE;
        end
    end

    // Operand capture on accept, then one chunk of shift per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            rem     <= '0;
            funct_q <= '0;
        end else if (flush_now) begin
            rem <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        funct_q <= in_funct;
                        acc     <= in_a;
                        rem     <= in_n;
                    end
                end
                S_RUN: begin
                    acc <= shifted;
                    rem <= rem_after;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer: directed cases,
//               backpressure, abort, and randomized ops against a reference
//               model built from the shift arithmetic and chunk-count rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int STEP = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_funct  = 2'b00;
    logic [31:0] in_a      = 32'h0;
    logic [4:0]  in_n      = 5'd0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] out_r;
`ifdef SHSEQ_FLUSH_EN
    logic        flush     = 1'b0;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    shift_sequencer #(
        .WIDTH   (32),
        .SHAMT_W (5),
        .STEP    (STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SHSEQ_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_funct  (in_funct),
        .in_a      (in_a),
        .in_n      (in_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain shift arithmetic; SRA built as logical shift plus sign fill
    function automatic logic [31:0] ref_shift(input logic [1:0] f, input logic [31:0] a, input int n);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        if (f == 2'b00) return a << n;
        if (f == 2'b11) return (a >> n) | (a[31] ? ~(ones >> n) : 32'h0);
        return a >> n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with bp cycles of out_ready backpressure in DONE
    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                          input int n, input int bp);
        logic [31:0] exp;
        logic [31:0] held;
        int          k;
        int          waited;
        exp = ref_shift(f, a, n);
        k   = (n + STEP - 1) / STEP;
        check({tag, " in_ready before"}, {31'd0, in_ready}, 32'd1);
        in_funct  = f;
        in_a      = a;
        in_n      = 5'(n);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_a     = $urandom;
        in_funct = 2'($urandom);
        in_n     = 5'($urandom);
        waited   = 0;
        while (!out_valid && waited < 64) begin
            tick();
            waited++;
        end
        // edges from accept to the edge where out_valid is first sampled high
        check({tag, " latency"}, 32'(waited + 1), 32'(k + 1));
        check({tag, " result"}, out_r, exp);
        check({tag, " busy done"}, {31'd0, busy}, 32'd1);
        held = out_r;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            tick();
            check({tag, " bp valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, " bp data"}, out_r, held);
            check({tag, " bp in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " post valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " post out_r"}, out_r, 32'h0);
        check({tag, " post in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, " post busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Watch for a stray result over a window of cycles
    task automatic expect_silence(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst out_r", out_r, 32'h0);
        rst_n = 1'b1;
        tick();
        check("rst in_ready", {31'd0, in_ready}, 32'd1);

        // Directed cases
        run_op("sll4",   2'b00, 32'h0000_F0F0, 4,  0);
        check("sll4 model", ref_shift(2'b00, 32'h0000_F0F0, 4), 32'h000F_0F00);
        run_op("sra13",  2'b11, 32'hF000_0000, 13, 0);
        run_op("sra4p",  2'b11, 32'h7000_0000, 4,  1);
        run_op("srl31a", 2'b01, 32'hF000_0000, 31, 0);
        run_op("srl31b", 2'b10, 32'hF000_0000, 31, 0);
        run_op("sra0",   2'b11, 32'hF000_0000, 0,  0);
        run_op("bp3",    2'b00, 32'h1234_5678, 9,  3);
        run_op("sll31",  2'b00, 32'h0000_0003, 31, 2);

        // Abort by reset in the middle of RUN
        in_funct = 2'b01;
        in_a     = 32'hDEAD_BEEF;
        in_n     = 5'd31;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("abort busy pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort out_r", out_r, 32'h0);
        tick();
        rst_n = 1'b1;
        expect_silence("abort no result", 12);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);

`ifdef SHSEQ_FLUSH_EN
        // Flush in the middle of RUN
        in_funct = 2'b11;
        in_a     = 32'h8000_0001;
        in_n     = 5'd30;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        expect_silence("flush no result", 12);
        // A request presented together with flush is not taken
        in_n     = 5'd8;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush reject busy", {31'd0, busy}, 32'd0);
        run_op("post flush", 2'b00, 32'h0000_00FF, 8, 0);
`endif

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            run_op("rand", 2'($urandom), $urandom, int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_shift_sequencer
`default_nettype wire

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller for the MIPS execute stage.
- Accepts one shift op (funct, operand, shift amount) over a valid/ready handshake.
- Splits the shift amount into chunks of at most STEP bits and drives the combinational `shifter` once per cycle on an internal accumulator.
- Returns the result over a second valid/ready handshake, so a narrow-step shifter can serve full 0..31 shifts.

Parameters:
- WIDTH, 32, operand/result width; fixed at 32 for this core.
- SHAMT_W, 5, shift-amount width.
- STEP, 4, maximum shift applied per RUN cycle; legal range 1..31.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_funct  in  2  00 SLL, 01 SRL, 10 SRL (alias), 11 SRA.
- in_a  in  32  operand.
- in_n  in  5  shift amount 0..31.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_r  out  32  shifted result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: asynchronous on rst_n low; state=IDLE, acc=0, rem=0, funct reg=0. in_ready=1 after reset release; out_valid=0, out_r=0, busy=0. Reset asserted mid-RUN or mid-DONE aborts the op; no result is produced.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch funct, acc<=in_a, rem<=in_n.
  - Next state is DONE if in_n==0, else RUN.
- RUN:
  - in_ready=0.
  - Each cycle: step=min(rem, STEP); acc<=shifter(funct, acc, step); rem<=rem-step.
  - Go to DONE when rem-step==0.
  - SRA sign preserved across chunks; SRL/SLL zero-fill.
- DONE:
  - out_valid=1, out_r=acc.
  - out_r and out_valid held stable until out_ready.
  - On out_valid & out_ready go to IDLE. The new request is accepted no earlier than the following cycle; no overlap.
- Latency: k=ceil(in_n/STEP) RUN cycles. out_valid rises k+1 cycles after the accept edge (1 cycle for in_n==0). Throughput is one op per k+2 cycles minimum.
- out_r is 0 outside DONE.
- in_valid while busy is ignored. The requester must hold its inputs until in_ready.
- in_funct is 2 bits; any X in it must not corrupt state (verification checks funct=10 behaves as SRL).
- in_n=31 with STEP=4: chunks 4,4,4,4,4,4,4,3.

Optional Feature:
- Macro SHSEQ_FLUSH_EN.
- When defined: adds input port flush (1 bit). flush high on a clock edge forces state to IDLE, rem=0, out_valid=0 next cycle, from any state. flush has priority over in_valid and out_ready in the same cycle. A request presented with flush high is not accepted.
- When undefined: no flush port; only rst_n aborts an op.

Decomposition:
- Package shseq_pkg:
  - funct localparams (FN_SLL=2'b00, FN_SRL=2'b01, FN_SRL2=2'b10, FN_SRA=2'b11).
  - State encoding (S_IDLE, S_RUN, S_DONE).
  - WIDTH/SHAMT_W defaults.
- One sub-module: the existing combinational `shifter` (funct, a, N -> R), instantiated once. Its N input is driven by step, its a input by acc.
- Step-min and remaining-count logic stays in shift_sequencer.

Test Plan:
- SLL, a=0x0000F0F0, n=4, STEP=4 -> one RUN cycle; out_valid 2 cycles after accept; out_r=0x000F0F00.
- SRA, a=0xF0000000, n=13 -> chunks 4,4,4,1; out_valid 5 cycles after accept; out_r=0xFFFF8000. SRA a=0x70000000, n=4 -> 0x07000000.
- SRL (funct=01 and 10), a=0xF0000000, n=31 -> 8 RUN cycles; out_r=0x00000001 for both encodings.
- Zero shift: SRA, a=0xF0000000, n=0 -> no RUN; out_valid 1 cycle after accept; out_r=0xF0000000.
- Backpressure: out_ready low 3 cycles in DONE -> out_r/out_valid stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE, next request accepted the following cycle.
- Abort: rst_n low mid-RUN -> immediate IDLE, out_valid=0, busy=0, out_r=0. With SHSEQ_FLUSH_EN, flush mid-RUN -> IDLE next cycle, and no result for that op ever appears.
